vp_decoder: RTL

- Consumer end of the VP encoder's ping-pong output.
- Takes the left and right 3-entry buffers (addr, weight, activation) in strict alternation, latches each one and releases it with a one-cycle ack.
- Forms signed weight×activation products, one per cycle, and streams them to the partial-sum accumulator over a valid/ready port.
- Sits between the VP encoder and the PE psum memory.

---
 rtl/vp_decoder.sv | 111 +++++++++++
 1 files changed

// File: rtl/vp_decoder.sv
// vp_decoder: drains the VP encoder's left/right ping-pong buffers in strict alternation
// and streams signed w*ia products; define VPDEC_COALESCE_EN to merge same-address runs.
module vp_decoder #(
  parameter int ENTRIES = 3,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 7,
  parameter int PSUM_W  = 32
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_left_ready,
  input  logic                          i_right_ready,
  input  logic [1:0]                    i_left_cnt,
  input  logic [1:0]                    i_right_cnt,
  input  logic [ENTRIES*3*ADDR_W-1:0]   i_addr_left_buffer,
  input  logic [ENTRIES*DATA_W-1:0]     i_w_data_left_buffer,
  input  logic [ENTRIES*DATA_W-1:0]     i_ia_data_left_buffer,
  input  logic [ENTRIES*3*ADDR_W-1:0]   i_addr_right_buffer,
  input  logic [ENTRIES*DATA_W-1:0]     i_w_data_right_buffer,
  input  logic [ENTRIES*DATA_W-1:0]     i_ia_data_right_buffer,
  output logic                          o_left_ack,
  output logic                          o_right_ack,
  output logic                          o_psum_valid,
  input  logic                          i_psum_ready,
  output logic [3*ADDR_W-1:0]           o_psum_addr,
  output logic [PSUM_W-1:0]             o_psum_data,
  output logic                          o_busy
);
  localparam int AW = 3*ADDR_W;
  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;
  state_t state;
  logic side;
  logic [1:0] cnt_q, idx, nxt, cnt_in, cnt_c;
  logic [ENTRIES*AW-1:0] addr_q;
  logic [ENTRIES*DATA_W-1:0] w_q, ia_q;
  logic signed [PSUM_W-1:0] sum;
  logic take, advance;
  function automatic logic signed [PSUM_W-1:0] prod_at(input int k);
    logic signed [2*DATA_W-1:0] p;
    p = $signed(w_q[k*DATA_W +: DATA_W]) * $signed(ia_q[k*DATA_W +: DATA_W]);
    return PSUM_W'(p);
  endfunction
  function automatic logic [AW-1:0] addr_at(input int k);
    return addr_q[k*AW +: AW];
  endfunction
  assign cnt_in  = side ? i_right_cnt : i_left_cnt;
  assign cnt_c   = (cnt_in > 2'(ENTRIES)) ? 2'(ENTRIES) : cnt_in;
  assign take    = (state == IDLE) && (side ? i_right_ready : i_left_ready);
  assign advance = !o_psum_valid || i_psum_ready;
  assign o_busy  = state != IDLE;
  // the group starting at idx is folded into one product; nxt is the first entry after it
  always_comb begin
    sum = prod_at(32'(idx));
    nxt = idx + 2'd1;
`ifdef VPDEC_COALESCE_EN
    begin
      logic run;
      run = 1'b1;
      for (int j = 1; j < ENTRIES; j++)
        if (run && (32'(idx) + 32'(j) < 32'(cnt_q)) && addr_at(32'(idx) + j) == addr_at(32'(idx))) begin
          sum = sum + prod_at(32'(idx) + j);
          nxt = 2'(32'(idx) + 32'(j) + 32'd1);
        end else
          run = 1'b0;
    end
`endif
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state        <= IDLE;
      side         <= 1'b0;
      cnt_q        <= '0;
      idx          <= '0;
      addr_q       <= '0;
      w_q          <= '0;
      ia_q         <= '0;
      o_left_ack   <= 1'b0;
      o_right_ack  <= 1'b0;
      o_psum_valid <= 1'b0;
      o_psum_addr  <= '0;
      o_psum_data  <= '0;
    end else begin
      o_left_ack  <= 1'b0;
      o_right_ack <= 1'b0;
      case (state)
        IDLE: if (take) begin
          addr_q      <= side ? i_addr_right_buffer : i_addr_left_buffer;
          w_q         <= side ? i_w_data_right_buffer : i_w_data_left_buffer;
          ia_q        <= side ? i_ia_data_right_buffer : i_ia_data_left_buffer;
          cnt_q       <= cnt_c;
          idx         <= '0;
          o_left_ack  <= !side;
          o_right_ack <= side;
          side        <= !side;
          state       <= (cnt_c != 2'd0) ? DRAIN : IDLE;
        end
        DRAIN: if (advance) begin
          o_psum_valid <= 1'b1;
          o_psum_data  <= sum;
          o_psum_addr  <= addr_at(32'(idx));
          idx          <= nxt;
          if (nxt >= cnt_q) state <= FLUSH;
        end
        FLUSH: if (advance) begin
          o_psum_valid <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
